// File: rtl/utc_time_rx_pkg.sv
// Shared constants, state/error encodings and the range check for the
// UTC timecode frame decoder.
package utc_time_rx_pkg;

  localparam logic [7:0] SYNC0       = 8'hA5;
  localparam logic [7:0] SYNC1       = 8'h5A;
  localparam int         PAYLOAD_LEN = 6;

  typedef enum logic [1:0] {
    HUNT0,
    HUNT1,
    PAYLOAD,
    CHECK
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_CHECKSUM = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_e;

  localparam logic [7:0] SEC_LIMIT  = 8'd60;
  localparam logic [7:0] MIN_LIMIT  = 8'd60;
  localparam logic [7:0] HOUR_LIMIT = 8'd24;
  localparam logic [7:0] DAY_MAX    = 8'd31;
  localparam logic [7:0] MONTH_MAX  = 8'd12;

  // Checked on the full received bytes, before truncation to field widths.
  function automatic logic fields_in_range(input logic [7:0] sec,
                                           input logic [7:0] minute,
                                           input logic [7:0] hour,
                                           input logic [7:0] day,
                                           input logic [7:0] month);
    return (sec < SEC_LIMIT) && (minute < MIN_LIMIT) && (hour < HOUR_LIMIT) &&
           (day != 8'd0) && (day <= DAY_MAX) &&
           (month != 8'd0) && (month <= MONTH_MAX);
  endfunction

endpackage

// File: rtl/utc_time_rx.sv
// Byte-stream timecode decoder: hunts for A5 5A, collects six payload bytes,
// validates checksum and ranges, and publishes held UTC fields with a pulse.
module utc_time_rx
  import utc_time_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             utc_time_update,
  output logic [5:0]       utc_time_second,
  output logic [5:0]       utc_time_minute,
  output logic [4:0]       utc_time_hour,
  output logic [4:0]       utc_time_day,
  output logic [3:0]       utc_time_month,
  output logic [7:0]       utc_time_year,
  output logic [CNT_W-1:0] frame_ok_cnt,
  output logic [CNT_W-1:0] frame_err_cnt,
  output logic [1:0]       last_err
);

  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam int IDX_W = $clog2(PAYLOAD_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_LEN - 1);

  state_e            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [7:0]        r_xor, w_xor_nxt;
  logic [IDLE_W-1:0] r_idle, w_idle_nxt;
  logic [7:0]        r_payload [PAYLOAD_LEN];

  logic              w_good, w_fail, w_timeout, w_chk_ok, w_rng_ok;
  err_e              w_fail_code;

  logic              r_update;
  logic [5:0]        r_sec, r_min;
  logic [4:0]        r_hour, r_day;
  logic [3:0]        r_month;
  logic [7:0]        r_year;
  logic [CNT_W-1:0]  r_ok_cnt, r_err_cnt;
  err_e              r_last_err;

  always_comb begin
    w_chk_ok    = (rx_data == r_xor);
    w_rng_ok    = fields_in_range(r_payload[0], r_payload[1], r_payload[2],
                                  r_payload[3], r_payload[4]);
    w_timeout   = (r_state != HUNT0) && !rx_valid && (r_idle == IDLE_LAST);
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_xor_nxt   = r_xor;
    w_idle_nxt  = (rx_valid || r_state == HUNT0) ? '0 : r_idle + 1'b1;
    w_good      = 1'b0;
    w_fail      = 1'b0;
    w_fail_code = ERR_NONE;
    // A byte on the final idle clock suppresses the timeout.
    if (w_timeout) begin
      w_state_nxt = HUNT0;
      w_idle_nxt  = '0;
      w_fail      = 1'b1;
      w_fail_code = ERR_TIMEOUT;
    end else if (rx_valid) begin
      case (r_state)
        HUNT0: begin
          if (rx_data == SYNC0) w_state_nxt = HUNT1;
        end
        HUNT1: begin
          if (rx_data == SYNC1) begin
            w_state_nxt = PAYLOAD;
            w_idx_nxt   = '0;
            w_xor_nxt   = '0;
          end else if (rx_data != SYNC0) begin
            w_state_nxt = HUNT0;
          end
        end
        PAYLOAD: begin
          w_xor_nxt = r_xor ^ rx_data;
          if (r_idx == IDX_LAST) w_state_nxt = CHECK;
          else                   w_idx_nxt   = r_idx + 1'b1;
        end
        CHECK: begin
          w_state_nxt = HUNT0;
          if (!w_chk_ok) begin
            w_fail      = 1'b1;
            w_fail_code = ERR_CHECKSUM;
          end else if (!w_rng_ok) begin
            w_fail      = 1'b1;
            w_fail_code = ERR_RANGE;
          end else begin
            w_good = 1'b1;
          end
        end
        default: w_state_nxt = HUNT0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT0;
      r_idx   <= '0;
      r_xor   <= '0;
      r_idle  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_xor   <= w_xor_nxt;
      r_idle  <= w_idle_nxt;
    end
  end

  // Payload bytes are pure data; they are only consumed after a full frame.
  always_ff @(posedge clk) begin
    if (r_state == PAYLOAD && rx_valid) r_payload[r_idx] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_update   <= 1'b0;
      r_sec      <= '0;
      r_min      <= '0;
      r_hour     <= '0;
      r_day      <= '0;
      r_month    <= '0;
      r_year     <= '0;
      r_ok_cnt   <= '0;
      r_err_cnt  <= '0;
      r_last_err <= ERR_NONE;
    end else begin
      r_update <= w_good;
      if (w_good) begin
        r_sec   <= r_payload[0][5:0];
        r_min   <= r_payload[1][5:0];
        r_hour  <= r_payload[2][4:0];
        r_day   <= r_payload[3][4:0];
        r_month <= r_payload[4][3:0];
        r_year  <= r_payload[5];
        if (r_ok_cnt != '1) r_ok_cnt <= r_ok_cnt + 1'b1;
      end
      if (w_fail) begin
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
        r_last_err <= w_fail_code;
      end
    end
  end

  assign utc_time_update = r_update;
  assign utc_time_second = r_sec;
  assign utc_time_minute = r_min;
  assign utc_time_hour   = r_hour;
  assign utc_time_day    = r_day;
  assign utc_time_month  = r_month;
  assign utc_time_year   = r_year;
  assign frame_ok_cnt    = r_ok_cnt;
  assign frame_err_cnt   = r_err_cnt;
  assign last_err        = r_last_err;

endmodule

// File: tb/tb_utc_time_rx.sv
// Scoreboard bench for utc_time_rx: a frame model pushes the expected outcome
// of each frame; a negedge monitor pops it when the DUT reports a result.
module tb_utc_time_rx;

  localparam int TO   = 16;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          utc_time_update;
  logic [5:0]    utc_time_second, utc_time_minute;
  logic [4:0]    utc_time_hour, utc_time_day;
  logic [3:0]    utc_time_month;
  logic [7:0]    utc_time_year;
  logic [CW-1:0] frame_ok_cnt, frame_err_cnt;
  logic [1:0]    last_err;

  always #5 clk = ~clk;

  utc_time_rx #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .utc_time_update(utc_time_update),
    .utc_time_second(utc_time_second), .utc_time_minute(utc_time_minute),
    .utc_time_hour(utc_time_hour), .utc_time_day(utc_time_day),
    .utc_time_month(utc_time_month), .utc_time_year(utc_time_year),
    .frame_ok_cnt(frame_ok_cnt), .frame_err_cnt(frame_err_cnt),
    .last_err(last_err)
  );

  typedef struct {
    logic       upd;
    logic [5:0] sec;
    logic [5:0] minute;
    logic [4:0] hour;
    logic [4:0] day;
    logic [3:0] month;
    logic [7:0] year;
    int         ok;
    int         err;
    int         last;
  } exp_t;

  exp_t q[$];
  exp_t m;
  exp_t e_mon;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xor6(input logic [47:0] pl);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 6; i++) x ^= pl[47-8*i -: 8];
    return x;
  endfunction

  function automatic logic in_range(input logic [47:0] pl);
    return (pl[47:40] < 60) && (pl[39:32] < 60) && (pl[31:24] < 24) &&
           (pl[23:16] >= 1) && (pl[23:16] <= 31) &&
           (pl[15:8] >= 1) && (pl[15:8] <= 12);
  endfunction

  task automatic post_fail(input int code);
    exp_t e;
    if (m.err < CMAX) m.err++;
    m.last = code;
    e = m;
    e.upd = 1'b0;
    q.push_back(e);
  endtask

  task automatic expect_frame(input logic [47:0] pl, input logic [7:0] chk);
    exp_t e;
    if (chk != xor6(pl)) begin
      post_fail(1);
    end else if (!in_range(pl)) begin
      post_fail(2);
    end else begin
      if (m.ok < CMAX) m.ok++;
      m.sec    = pl[45:40];
      m.minute = pl[37:32];
      m.hour   = pl[28:24];
      m.day    = pl[20:16];
      m.month  = pl[11:8];
      m.year   = pl[7:0];
      e = m;
      e.upd = 1'b1;
      q.push_back(e);
    end
  endtask

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
    end
  endtask

  task automatic send_payload(input logic [47:0] pl, input logic [7:0] chk);
    expect_frame(pl, chk);
    for (int i = 0; i < 6; i++) drive(pl[47-8*i -: 8]);
    drive(chk);
  endtask

  task automatic send_frame(input logic [47:0] pl, input logic [7:0] chk);
    drive(8'hA5);
    drive(8'h5A);
    send_payload(pl, chk);
  endtask

  task automatic drained(input string tag);
    idle(3);
    check(tag, q.size(), 0);
  endtask

  logic          prev_upd = 1'b0;
  logic [CW-1:0] prev_err = '0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (prev_upd) check("single_pulse", utc_time_update, 0);
      if (utc_time_update || frame_err_cnt != prev_err) begin
        if (q.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          e_mon = q.pop_front();
          check("update", utc_time_update, e_mon.upd);
          check("sec", utc_time_second, e_mon.sec);
          check("min", utc_time_minute, e_mon.minute);
          check("hour", utc_time_hour, e_mon.hour);
          check("day", utc_time_day, e_mon.day);
          check("month", utc_time_month, e_mon.month);
          check("year", utc_time_year, e_mon.year);
          check("ok_cnt", frame_ok_cnt, e_mon.ok);
          check("err_cnt", frame_err_cnt, e_mon.err);
          check("last_err", last_err, e_mon.last);
        end
      end
    end
    prev_upd = utc_time_update;
    prev_err = frame_err_cnt;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_upd"}, utc_time_update, 0);
    check({tag, "_fields"}, {utc_time_second, utc_time_minute, utc_time_hour,
                             utc_time_day, utc_time_month, utc_time_year}, 0);
    check({tag, "_ok"}, frame_ok_cnt, 0);
    check({tag, "_err"}, frame_err_cnt, 0);
    check({tag, "_last"}, last_err, 0);
  endtask

  localparam logic [47:0] GOOD  = 48'h1E2D0C0F0619;
  localparam logic [47:0] MAXF  = 48'h3B3B171F0CFF;
  localparam logic [47:0] MINF  = 48'h000000010100;
  localparam logic [47:0] SEQ   = 48'h010203040506;

  initial begin
    logic [47:0] pl;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    m = '{default: 0};
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    send_frame(GOOD, xor6(GOOD));
    drained("drain_good");

    send_frame(GOOD, xor6(GOOD) ^ 8'h01);
    drained("drain_badchk");

    pl = 48'h1E2D180F0619;
    send_frame(pl, xor6(pl));
    drained("drain_hour");

    pl = 48'h1E2D0C0F0019;
    send_frame(pl, xor6(pl));
    drained("drain_month");

    drive(8'h00);
    drive(8'hA5);
    drive(8'hA5);
    drive(8'h5A);
    send_payload(MAXF, xor6(MAXF));
    drained("drain_resync");

    post_fail(3);
    drive(8'hA5);
    drive(8'h5A);
    drive(8'h01);
    idle(16);
    drained("drain_timeout");
    drive(8'h5A);
    send_frame(MINF, xor6(MINF));
    drained("drain_after_to");

    expect_frame(SEQ, xor6(SEQ));
    drive(8'hA5);
    drive(8'h5A);
    drive(8'h01);
    idle(TO - 1);
    for (int i = 1; i < 6; i++) drive(SEQ[47-8*i -: 8]);
    drive(xor6(SEQ));
    drained("drain_late_byte");

    send_frame(GOOD, xor6(GOOD));
    send_frame(MINF, xor6(MINF));
    drained("drain_b2b");

    drive(8'hA5);
    drive(8'h5A);
    drive(8'h1E);
    drive(8'h2D);
    @(negedge clk);
    #1 rst_n    = 1'b0;
    rx_valid = 1'b0;
    #1 check_all_zero("midreset");
    m = '{default: 0};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send_frame(MAXF, xor6(MAXF));
    drained("drain_post_reset");

    for (int i = 0; i < CMAX + 2; i++) send_frame(GOOD, xor6(GOOD));
    drained("drain_sat");
    check("ok_saturated", frame_ok_cnt, CMAX);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
